// File: rtl/multicycle_controller_pkg.sv
// Shared types and constants for the multicycle MIPS controller: state encoding,
// opcode/funct values, ALU control codes and the per-state control word.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        RTYPEEX  = 4'd6,
        RTYPEWB  = 4'd7,
        BEQEX    = 4'd8,
        ADDIEX   = 4'd9,
        ADDIWB   = 4'd10,
        JEX      = 4'd11,
        MULTEX   = 4'd12,
        MULTWAIT = 4'd13
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_MULT = 6'b011000;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       mstart;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
    } ctrl_t;

    // Moore output table: the control word each state drives for its whole cycle.
    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.irwrite = 1'b1;
                c.pcwrite = 1'b1;
                c.alusrcb = 2'b01;
            end
            DECODE:  c.alusrcb = 2'b11;
            MEMADR, ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            MEMRD:   c.iord = 1'b1;
            MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            MEMWR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            RTYPEEX: begin
                c.alusrca = 1'b1;
                c.aluop   = ALUOP_FUNCT;
            end
            RTYPEWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            BEQEX: begin
                c.alusrca = 1'b1;
                c.aluop   = ALUOP_SUB;
                c.pcsrc   = 2'b01;
                c.branch  = 1'b1;
            end
            ADDIWB:  c.regwrite = 1'b1;
            JEX: begin
                c.pcsrc   = 2'b10;
                c.pcwrite = 1'b1;
            end
            MULTEX:  c.mstart = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic is_alu_funct(input logic [5:0] f);
        return (f == F_ADD) || (f == F_SUB) || (f == F_AND) ||
               (f == F_OR)  || (f == F_SLT);
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps the FSM's aluop class plus the R-type funct field onto a 3-bit ALU control code.
module alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    // Unknown functs fall back to add; the FSM flags them illegal before they execute.
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    F_ADD:   alucontrol = ALU_ADD;
                    F_SUB:   alucontrol = ALU_SUB;
                    F_AND:   alucontrol = ALU_AND;
                    F_OR:    alucontrol = ALU_OR;
                    F_SLT:   alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM controller for a multicycle MIPS datapath with registered control outputs.
// Define MULTICYCLE_MULT_EN to route funct 011000 through the MULTEX/MULTWAIT handshake.
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mult_done,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       mult_start,
    output logic       illegal,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    state_t stateQ;
    state_t stateD;
    ctrl_t  ctrlQ;
    logic   opKnown;
    logic   functOk;
    logic   isMult;
    logic   decodeBad;

    // Instruction legality, only meaningful while the FSM sits in DECODE.
    always_comb begin
        isMult  = (funct == F_MULT);
        functOk = is_alu_funct(funct);
`ifdef MULTICYCLE_MULT_EN
        functOk = functOk | isMult;
`endif
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: opKnown = 1'b1;
            default:                                        opKnown = 1'b0;
        endcase
        decodeBad = !opKnown || ((op == OP_RTYPE) && !functOk);
    end

    always_comb begin
        stateD = FETCH;
        case (stateQ)
            FETCH:  stateD = DECODE;
            DECODE: begin
                if (decodeBad) begin
                    stateD = FETCH;
                end else begin
                    case (op)
                        OP_LW, OP_SW: stateD = MEMADR;
`ifdef MULTICYCLE_MULT_EN
                        OP_RTYPE:     stateD = isMult ? MULTEX : RTYPEEX;
`else
                        OP_RTYPE:     stateD = RTYPEEX;
`endif
                        OP_BEQ:       stateD = BEQEX;
                        OP_ADDI:      stateD = ADDIEX;
                        OP_J:         stateD = JEX;
                        default:      stateD = FETCH;
                    endcase
                end
            end
            MEMADR:   stateD = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:    stateD = MEMWB;
            RTYPEEX:  stateD = RTYPEWB;
            ADDIEX:   stateD = ADDIWB;
`ifdef MULTICYCLE_MULT_EN
            MULTEX:   stateD = MULTWAIT;
            MULTWAIT: stateD = mult_done ? FETCH : MULTWAIT;
`endif
            default:  stateD = FETCH;
        endcase
    end

    // The control word is loaded alongside the next state so outputs come straight off flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= FETCH;
            ctrlQ  <= state_ctrl(FETCH);
        end else begin
            stateQ <= stateD;
            ctrlQ  <= state_ctrl(stateD);
        end
    end

    alu_decoder uAluDecoder (
        .aluop      (ctrlQ.aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

    // Write strobes are gated by reset so nothing is committed while reset is held.
    assign pcen     = (ctrlQ.pcwrite | (ctrlQ.branch & zero)) & ~reset;
    assign memwrite = ctrlQ.memwrite & ~reset;
    assign irwrite  = ctrlQ.irwrite & ~reset;
    assign regwrite = ctrlQ.regwrite & ~reset;
    assign illegal  = (stateQ == DECODE) & decodeBad & ~reset;

`ifdef MULTICYCLE_MULT_EN
    assign mult_start = ctrlQ.mstart & ~reset;
`else
    logic [2:0] unused_mult;
    assign unused_mult = {mult_done, ctrlQ.mstart, isMult};
    assign mult_start  = 1'b0;
`endif

    assign iord     = ctrlQ.iord;
    assign memtoreg = ctrlQ.memtoreg;
    assign regdst   = ctrlQ.regdst;
    assign alusrca  = ctrlQ.alusrca;
    assign alusrcb  = ctrlQ.alusrcb;
    assign pcsrc    = ctrlQ.pcsrc;
    assign state    = stateQ;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus random instruction
// streams compared against a per-instruction state-sequence model.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       multDone;
    logic       pcen, memwrite, irwrite, regwrite, multStart, illegal;
    logic       iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    int nChecks = 0;
    int nFails  = 0;
    int expQ[$];

`ifdef MULTICYCLE_MULT_EN
    localparam bit MULT_EN = 1'b1;
`else
    localparam bit MULT_EN = 1'b0;
`endif

    typedef struct packed {
        logic       memWrite;
        logic       irWrite;
        logic       regWrite;
        logic       iorD;
        logic       memToReg;
        logic       regDst;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] pcSrc;
        logic       mStart;
    } obs_t;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mult_done  (multDone),
        .pcen       (pcen),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .mult_start (multStart),
        .illegal    (illegal),
        .iord       (iord),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .state      (state)
    );

    always #5 clk = ~clk;

    function automatic bit functLegal(input logic [5:0] f);
        return (f == 6'd32) || (f == 6'd34) || (f == 6'd36) || (f == 6'd37) ||
               (f == 6'd42) || (MULT_EN && f == 6'd24);
    endfunction

    function automatic bit instrIllegal(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'd0) return !functLegal(f);
        return !((o == 6'd35) || (o == 6'd43) || (o == 6'd4) || (o == 6'd8) || (o == 6'd2));
    endfunction

    // Expected state trace of one instruction, starting at its FETCH.
    function automatic void buildSeq(input logic [5:0] o, input logic [5:0] f, input int dly);
        expQ.delete();
        expQ.push_back(0);
        expQ.push_back(1);
        if (instrIllegal(o, f)) return;
        case (o)
            6'd35: begin expQ.push_back(2); expQ.push_back(3); expQ.push_back(4); end
            6'd43: begin expQ.push_back(2); expQ.push_back(5); end
            6'd4:  expQ.push_back(8);
            6'd8:  begin expQ.push_back(9); expQ.push_back(10); end
            6'd2:  expQ.push_back(11);
            default: begin
                if (f == 6'd24) begin
                    expQ.push_back(12);
                    for (int k = 0; k < dly; k++) expQ.push_back(13);
                end else begin
                    expQ.push_back(6);
                    expQ.push_back(7);
                end
            end
        endcase
    endfunction

    function automatic obs_t expObs(input int s);
        obs_t e;
        e = '0;
        case (s)
            0:  begin e.irWrite = 1'b1; e.aluSrcB = 2'b01; end
            1:  e.aluSrcB = 2'b11;
            2, 9: begin e.aluSrcA = 1'b1; e.aluSrcB = 2'b10; end
            3:  e.iorD = 1'b1;
            4:  begin e.memToReg = 1'b1; e.regWrite = 1'b1; end
            5:  begin e.iorD = 1'b1; e.memWrite = 1'b1; end
            6:  e.aluSrcA = 1'b1;
            7:  begin e.regDst = 1'b1; e.regWrite = 1'b1; end
            8:  begin e.aluSrcA = 1'b1; e.pcSrc = 2'b01; end
            10: e.regWrite = 1'b1;
            11: e.pcSrc = 2'b10;
            12: e.mStart = 1'b1;
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic logic expPcen(input int s, input logic z);
        return (s == 0) || (s == 11) || ((s == 8) && z);
    endfunction

    function automatic logic [2:0] expAlu(input int s, input logic [5:0] f);
        if (s == 8) return 3'b110;
        if (s != 6) return 3'b010;
        case (f)
            6'd32:   return 3'b010;
            6'd34:   return 3'b110;
            6'd36:   return 3'b000;
            6'd37:   return 3'b001;
            6'd42:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from FETCH, checking every cycle, then checks it retired to FETCH.
    task automatic runInstr(input string name, input logic [5:0] o, input logic [5:0] f,
                            input logic z, input int dly);
        obs_t got;
        obs_t want;
        buildSeq(o, f, dly);
        op    = o;
        funct = f;
        zero  = z;
        for (int i = 0; i < expQ.size(); i++) begin
            int s;
            s = expQ[i];
            if (s == 13) multDone = (i == expQ.size() - 1);
            else if (s == 0) multDone = 1'b1;
            else multDone = 1'($urandom_range(0, 1));
            #1;
            got  = {memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
                    alusrcb, pcsrc, multStart};
            want = expObs(s);
            nChecks++;
            if (state !== 4'(s)) begin
                nFails++;
                $display("[TB] FAIL %s state cyc%0d: got %0d want %0d", name, i, state, s);
            end
            nChecks++;
            if (got !== want) begin
                nFails++;
                $display("[TB] FAIL %s ctrl cyc%0d: got %b want %b", name, i, got, want);
            end
            nChecks++;
            if (pcen !== expPcen(s, z)) begin
                nFails++;
                $display("[TB] FAIL %s pcen cyc%0d: got %b want %b", name, i, pcen, expPcen(s, z));
            end
            nChecks++;
            if (illegal !== ((s == 1) && instrIllegal(o, f))) begin
                nFails++;
                $display("[TB] FAIL %s illegal cyc%0d: got %b", name, i, illegal);
            end
            nChecks++;
            if (alucontrol !== expAlu(s, f)) begin
                nFails++;
                $display("[TB] FAIL %s alucontrol cyc%0d: got %b want %b", name, i, alucontrol,
                         expAlu(s, f));
            end
            step();
        end
        multDone = 1'b0;
        nChecks++;
        if (state !== 4'd0) begin
            nFails++;
            $display("[TB] FAIL %s retire: state %0d want 0 after %0d cycles", name, state,
                     expQ.size());
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        op       = 6'd0;
        funct    = 6'd32;
        zero     = 1'b0;
        multDone = 1'b0;
        step();
        step();
        nChecks++;
        if (state !== 4'd0) begin
            nFails++;
            $display("[TB] FAIL reset state: got %0d want 0", state);
        end
        nChecks++;
        if ({pcen, memwrite, irwrite, regwrite, multStart, illegal} !== 6'b0) begin
            nFails++;
            $display("[TB] FAIL reset strobes: got %b want 000000",
                     {pcen, memwrite, irwrite, regwrite, multStart, illegal});
        end
        reset = 1'b0;
        #1;
        nChecks++;
        if ({irwrite, pcen} !== 2'b11) begin
            nFails++;
            $display("[TB] FAIL reset release fetch: got %b want 11", {irwrite, pcen});
        end
    endtask

    task automatic test_lw();
        runInstr("lw", 6'b100011, 6'd0, 1'b0, 0);
        runInstr("sw", 6'b101011, 6'd0, 1'b1, 0);
        runInstr("addi", 6'b001000, 6'd0, 1'b0, 0);
        runInstr("j", 6'b000010, 6'd0, 1'b1, 0);
    endtask

    task automatic test_beq();
        runInstr("beq_taken", 6'b000100, 6'd0, 1'b1, 0);
        runInstr("beq_not_taken", 6'b000100, 6'd0, 1'b0, 0);
    endtask

    task automatic test_rtype();
        runInstr("rtype_sub", 6'b000000, 6'b100010, 1'b0, 0);
        runInstr("rtype_slt", 6'b000000, 6'b101010, 1'b0, 0);
        runInstr("rtype_and", 6'b000000, 6'b100100, 1'b1, 0);
        runInstr("rtype_or", 6'b000000, 6'b100101, 1'b0, 0);
    endtask

    task automatic test_mult();
        runInstr("mult", 6'b000000, 6'b011000, 1'b0, 3);
        runInstr("mult_fast", 6'b000000, 6'b011000, 1'b0, 1);
    endtask

    task automatic test_illegal();
        runInstr("illegal_op", 6'b111111, 6'd0, 1'b0, 0);
        runInstr("illegal_funct", 6'b000000, 6'b000111, 1'b0, 0);
    endtask

    task automatic test_reset_midinstr();
        op    = 6'b101011;
        funct = 6'd0;
        zero  = 1'b0;
        step();
        step();
        step();
        nChecks++;
        if ({state, memwrite} !== {4'd5, 1'b1}) begin
            nFails++;
            $display("[TB] FAIL midreset pre: state %0d memwrite %b want 5/1", state, memwrite);
        end
        reset = 1'b1;
        #1;
        nChecks++;
        if ({memwrite, pcen} !== 2'b00) begin
            nFails++;
            $display("[TB] FAIL midreset memwrite: got %b want 00", {memwrite, pcen});
        end
        step();
        nChecks++;
        if (state !== 4'd0) begin
            nFails++;
            $display("[TB] FAIL midreset next: state %0d want 0", state);
        end
        if (MULT_EN) begin
            reset = 1'b0;
            op    = 6'd0;
            funct = 6'b011000;
            multDone = 1'b0;
            for (int k = 0; k < 5; k++) step();
            nChecks++;
            if ({state, multStart} !== {4'd13, 1'b0}) begin
                nFails++;
                $display("[TB] FAIL multwait hold: state %0d start %b want 13/0", state,
                         multStart);
            end
            reset = 1'b1;
            step();
            nChecks++;
            if (state !== 4'd0) begin
                nFails++;
                $display("[TB] FAIL multwait reset: state %0d want 0", state);
            end
        end
        reset = 1'b0;
        #1;
    endtask

    task automatic test_random();
        logic [5:0] ops[7];
        logic [5:0] fns[7];
        ops = '{6'd35, 6'd43, 6'd0, 6'd4, 6'd8, 6'd2, 6'd0};
        fns = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd24, 6'd0};
        for (int n = 0; n < 40; n++) begin
            logic [5:0] o;
            logic [5:0] f;
            int pick;
            pick = $urandom_range(0, 7);
            o = (pick == 7) ? 6'($urandom) : ops[pick];
            pick = $urandom_range(0, 7);
            f = (pick == 7) ? 6'($urandom) : fns[pick];
            runInstr("random", o, f, 1'($urandom_range(0, 1)), $urandom_range(1, 6));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_lw();
        test_beq();
        test_rtype();
        test_mult();
        test_illegal();
        test_reset_midinstr();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have clk, input, 1: sole clock; all state changes on its rising edge.
REQ-002 SHALL have reset, input, 1: synchronous, active-high reset.
REQ-003 SHALL have op, input, 6: instr[31:26]; funct, input, 6: instr[5:0]; zero, input, 1: ALU zero flag.
REQ-004 SHALL have mult_done, input, 1: multiplier-finished pulse.
REQ-005 SHALL have outputs:
- 1-bit strobes: pcen, memwrite, irwrite, regwrite, mult_start, illegal.
- 1-bit mux selects: iord, memtoreg, regdst, alusrca.
- 2-bit mux selects: alusrcb, pcsrc.
- alucontrol, 3 bits.
- state, 4 bits: debug view of the current state.

Function
REQ-006 SHALL be a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11, MULTEX=12, MULTWAIT=13; codes 14-15 SHALL go to FETCH.
REQ-007 Transitions SHALL be:
- FETCH->DECODE.
- DECODE by op: 100011/101011->MEMADR; 000000->RTYPEEX (or MULTEX, REQ-018); 000100->BEQEX; 001000->ADDIEX; 000010->JEX; any other->FETCH.
- MEMADR->MEMRD (lw) or MEMWR (sw).
- MEMRD->MEMWB; RTYPEEX->RTYPEWB; ADDIEX->ADDIWB.
- MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX, JEX->FETCH.
REQ-008 Per-state outputs SHALL be as below; any signal not listed is 0:
- FETCH: irwrite=1, pcwrite=1, alusrcb=01.
- DECODE: alusrcb=11.
- MEMADR, ADDIEX: alusrca=1, alusrcb=10.
- MEMRD: iord=1.
- MEMWB: memtoreg=1, regwrite=1.
- MEMWR: iord=1, memwrite=1.
- RTYPEEX: alusrca=1, aluop=10.
- RTYPEWB: regdst=1, regwrite=1.
- BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1.
- ADDIWB: regwrite=1.
- JEX: pcsrc=10, pcwrite=1.
REQ-009 pcen SHALL equal pcwrite | (branch & zero), combinationally from the current state and zero.
REQ-010 alucontrol SHALL be derived from aluop and funct:
- aluop 00 -> 010; aluop 01 -> 110.
- aluop 10 by funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, any other->010.
REQ-011 illegal SHALL be 1 for exactly one cycle in DECODE when op is unrecognised, or when op=000000 and funct is not listed in REQ-010 (and not 011000 when MULT_EN is defined); the instruction is then retired as a NOP (DECODE->FETCH, no regwrite).
REQ-012 Cycle counts SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
REQ-013 MULTEX SHALL assert mult_start for exactly one cycle, then go to MULTWAIT.
REQ-014 MULTWAIT SHALL hold until a cycle with mult_done=1, then go to FETCH; MULTWAIT has no timeout.
REQ-015 A mult_done pulse received outside MULTWAIT SHALL be ignored.

Reset
REQ-016 While reset=1, state SHALL load FETCH on the clock edge.
REQ-017 While reset=1, pcen, memwrite, irwrite, regwrite, mult_start and illegal SHALL be forced to 0 combinationally, with no partial write. Reset asserted mid-instruction (including in MULTWAIT) SHALL abandon the instruction, and the first cycle after reset SHALL be FETCH.

Configuration
REQ-018 Macro MULTICYCLE_MULT_EN:
- Defined: op=000000 with funct=011000 in DECODE SHALL go to MULTEX.
- Undefined: MULTEX and MULTWAIT SHALL be unreachable, mult_start SHALL be constant 0, mult_done SHALL be unused, and funct 011000 SHALL be illegal (REQ-011).
- Ports SHALL be identical in both builds.

Structure
REQ-019 A shared package SHALL hold:
- the state enum (4-bit);
- opcode constants OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J;
- funct constants including F_MULT;
- alucontrol codes.
REQ-020 The ALU decode (REQ-010) SHALL be a sub-module alu_decoder; the FSM and its output decode stay in multicycle_controller.

Verification
REQ-021 Reset held 2 cycles, then op=100011 -> state sequence 0,1,2,3,4,0; memtoreg=1 and regwrite=1 only in state 4; memwrite never 1.
REQ-022 op=000100, zero=1 in BEQEX -> pcen=1, pcsrc=01; repeat with zero=0 -> pcen=0; both runs 3 cycles.
REQ-023 op=000000, funct=100010 -> alucontrol=110 in RTYPEEX; regdst=1, regwrite=1 in RTYPEWB.
REQ-024 MULTICYCLE_MULT_EN defined, funct=011000, mult_done pulsed 3 cycles after MULTEX (plus a stray pulse during FETCH) -> mult_start high 1 cycle, stray pulse ignored, FETCH follows the done cycle. Macro undefined, same instruction -> illegal=1 for 1 cycle, mult_start stays 0.
REQ-025 op=111111 -> illegal=1 in DECODE, then FETCH, regwrite never 1.
REQ-026 reset asserted in MEMWR -> memwrite=0 that cycle; state=FETCH next cycle.
